cb_dbuf: RTL and testbench

- Second-generation connection box between NUM_LE logic elements and one switchbox/neighbour-CB track pair.
- Single serial configuration chain loads a shadow register while the previously committed active configuration keeps routing live, so there is no output blanking during reconfiguration.
- A frame controller counts shifted bits and accepts an atomic commit only for an exact-length frame.
- Generalises LE count and per-mux field packing.

---
 rtl/cb_pkg.sv | 26 ++
 rtl/cb_in_mux.sv | 31 +++
 rtl/cb_dbuf.sv | 166 ++++++++++++++++
 tb/tb_cb_dbuf.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// rtl/cb_pkg.sv - shared types and helpers for the cb_dbuf connection box
package cb_pkg;

    // Frame controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LOADED = 2'd2,
        ST_ERR    = 2'd3
    } cb_state_t;

    // Constant selects sit just above the track range
    localparam int CONST_0_OFS = 0;
    localparam int CONST_1_OFS = 1;

    function automatic int cb_sel_bits(input int width);
        return $clog2(width + 2);
    endfunction

    // Mux index k within the frame: LE-major, inputs first then outputs
    function automatic int cb_field_idx(input int le, input int idx, input logic le_io,
                                        input int le_inputs = 4, input int le_outputs = 1);
        return le * (le_inputs + le_outputs) + (le_io ? (le_inputs + idx) : idx);
    endfunction

endpackage

// File: rtl/cb_in_mux.sv
// rtl/cb_in_mux.sv - one LE-input select mux over tracks and constants
module cb_in_mux
    import cb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SEL_BITS = cb_sel_bits(WIDTH)
) (
    input  logic [SEL_BITS-1:0] sel_i,
    input  logic [WIDTH-1:0]    sb_bus_i,
    input  logic [WIDTH-1:0]    cb_bus_i,
    input  logic                valid_i,
    output logic                mux_o
);

    logic [WIDTH-1:0] trk;

    assign trk = sb_bus_i | cb_bus_i;

    // Track select, constant 0/1 selects, anything else reads as 0
    always_comb begin
        mux_o = 1'b0;
        if (valid_i) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (int'(sel_i) == j) mux_o = trk[j];
            end
            if (int'(sel_i) == WIDTH + CONST_0_OFS) mux_o = 1'b0;
            if (int'(sel_i) == WIDTH + CONST_1_OFS) mux_o = 1'b1;
        end
    end

endmodule

// File: rtl/cb_dbuf.sv
// rtl/cb_dbuf.sv - double-buffered connection box (optional CB_OUT_REG_EN output registers)
module cb_dbuf
    import cb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_LE     = 2,
    parameter int LE_INPUTS  = 4,
    parameter int LE_OUTPUTS = 1,
    parameter int SEL_BITS   = cb_sel_bits(WIDTH),
    parameter int CFG_BITS   = NUM_LE * (LE_INPUTS + LE_OUTPUTS) * SEL_BITS
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         en,
    input  logic                         config_en,
    input  logic                         config_data_in,
    output logic                         config_data_out,
    input  logic                         commit,
    output logic                         cfg_loaded,
    output logic                         frame_err,
    input  logic [WIDTH-1:0]             sb_bus_in,
    output logic [WIDTH-1:0]             sb_bus_out,
    input  logic [WIDTH-1:0]             cb_bus_in,
    output logic [WIDTH-1:0]             cb_bus_out,
    input  logic [NUM_LE*LE_OUTPUTS-1:0] le_out,
    output logic [NUM_LE*LE_INPUTS-1:0]  le_in
);

    localparam int CNT_W  = $clog2(CFG_BITS + 2);
    localparam int NUM_OM = NUM_LE * LE_OUTPUTS;

    cb_state_t           state_q, state_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic                active_valid_q, active_valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                shift_en;

    assign shift_en        = en & config_en;
    assign config_data_out = shadow_q[CFG_BITS-1];
    assign cfg_loaded      = (state_q == ST_LOADED);
    assign frame_err       = (state_q == ST_ERR);

    // Config state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= ST_IDLE;
            shadow_q       <= '1;
            active_q       <= '1;
            active_valid_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            active_valid_q <= active_valid_d;
            cnt_q          <= cnt_d;
        end
    end

    // Frame FSM: shift into shadow, judge frame length, commit shadow to active
    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        active_valid_d = active_valid_q;
        cnt_d          = cnt_q;
        if (shift_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], config_data_in};
            if (state_q != ST_SHIFT) begin
                state_d = ST_SHIFT;
                cnt_d   = CNT_W'(1);
            end else if (cnt_q != CNT_W'(CFG_BITS + 1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (en) begin
            case (state_q)
                ST_SHIFT: state_d = (cnt_q == CNT_W'(CFG_BITS)) ? ST_LOADED : ST_ERR;
                ST_LOADED: begin
                    if (commit) begin
                        active_d       = shadow_q;
                        active_valid_d = 1'b1;
                        state_d        = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [NUM_LE*LE_INPUTS-1:0] le_in_d;
    logic [WIDTH-1:0]            sb_out_d;
    logic [WIDTH-1:0]            cb_out_d;
    logic [SEL_BITS-1:0]         out_sel [NUM_OM];

    for (genvar g_le = 0; g_le < NUM_LE; g_le++) begin : g_le_blk
        for (genvar g_i = 0; g_i < LE_INPUTS; g_i++) begin : g_in_blk
            localparam int K = cb_field_idx(g_le, g_i, 1'b0, LE_INPUTS, LE_OUTPUTS);
            cb_in_mux #(
                .WIDTH    (WIDTH),
                .SEL_BITS (SEL_BITS)
            ) u_in_mux (
                .sel_i    (active_q[(K+1)*SEL_BITS-1 -: SEL_BITS]),
                .sb_bus_i (sb_bus_in),
                .cb_bus_i (cb_bus_in),
                .valid_i  (active_valid_q),
                .mux_o    (le_in_d[g_le*LE_INPUTS+g_i])
            );
        end
    end

    for (genvar g_m = 0; g_m < NUM_OM; g_m++) begin : g_out_sel
        localparam int K = cb_field_idx(g_m / LE_OUTPUTS, g_m % LE_OUTPUTS, 1'b1,
                                        LE_INPUTS, LE_OUTPUTS);
        assign out_sel[g_m] = active_q[(K+1)*SEL_BITS-1 -: SEL_BITS];
    end

    logic hit;
    logic drv;

    // Output drive: lowest-index matching LE output wins a track, else cross pass-through
    always_comb begin
        sb_out_d = cb_bus_in;
        cb_out_d = sb_bus_in;
        hit      = 1'b0;
        drv      = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            hit = 1'b0;
            drv = 1'b0;
            for (int m = 0; m < NUM_OM; m++) begin
                if (!hit && int'(out_sel[m]) == j) begin
                    hit = 1'b1;
                    drv = le_out[m];
                end
            end
            if (hit) begin
                sb_out_d[j] = drv;
                cb_out_d[j] = drv;
            end
        end
        if (!active_valid_q) begin
            sb_out_d = '0;
            cb_out_d = '0;
        end
    end

`ifdef CB_OUT_REG_EN
    // Registered routing outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            le_in      <= '0;
            sb_bus_out <= '0;
            cb_bus_out <= '0;
        end else begin
            le_in      <= le_in_d;
            sb_bus_out <= sb_out_d;
            cb_bus_out <= cb_out_d;
        end
    end
`else
    assign le_in      = le_in_d;
    assign sb_bus_out = sb_out_d;
    assign cb_bus_out = cb_out_d;
`endif

endmodule

// File: tb/tb_cb_dbuf.sv
// tb/tb_cb_dbuf.sv - self-checking bench for cb_dbuf
module tb_cb_dbuf;

    localparam int WIDTH = 32;
    localparam int NUM_LE = 2;
    localparam int LI = 4;
    localparam int LO = 1;
    localparam int SB = 6;
    localparam int NM = NUM_LE * (LI + LO);
    localparam int CFG = NM * SB;

    logic clk = 1'b0;
    logic nrst, en, config_en, config_data_in, commit;
    logic config_data_out, cfg_loaded, frame_err;
    logic [WIDTH-1:0] sb_bus_in, sb_bus_out, cb_bus_in, cb_bus_out;
    logic [NUM_LE*LO-1:0] le_out;
    logic [NUM_LE*LI-1:0] le_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cb_dbuf dut (
        .clk             (clk),
        .nrst            (nrst),
        .en              (en),
        .config_en       (config_en),
        .config_data_in  (config_data_in),
        .config_data_out (config_data_out),
        .commit          (commit),
        .cfg_loaded      (cfg_loaded),
        .frame_err       (frame_err),
        .sb_bus_in       (sb_bus_in),
        .sb_bus_out      (sb_bus_out),
        .cb_bus_in       (cb_bus_in),
        .cb_bus_out      (cb_bus_out),
        .le_out          (le_out),
        .le_in           (le_in)
    );

    // Reference model: last CFG shifted bits, frame bookkeeping, committed selects
    bit sh_q[$];
    bit m_shifting, m_loaded, m_err, m_valid;
    int m_bits;
    int m_act[NM];
    int f_sel[NM];
    logic [NUM_LE*LI-1:0] e_li;
    logic [WIDTH-1:0] e_sb, e_cb;

    function automatic void model_reset();
        sh_q.delete();
        for (int i = 0; i < CFG; i++) sh_q.push_back(1'b1);
        m_shifting = 0; m_loaded = 0; m_err = 0; m_valid = 0; m_bits = 0;
        for (int k = 0; k < NM; k++) m_act[k] = 63;
    endfunction

    function automatic int shadow_field(int k);
        int v = 0;
        for (int b = 0; b < SB; b++)
            if (sh_q[CFG-1-(k*SB+b)]) v |= (1 << b);
        return v;
    endfunction

    function automatic void model_edge();
        if (en && config_en) begin
            sh_q.push_back(config_data_in);
            if (sh_q.size() > CFG) void'(sh_q.pop_front());
            if (!m_shifting) begin
                m_shifting = 1; m_bits = 0; m_loaded = 0; m_err = 0;
            end
            m_bits++;
        end else if (en && m_shifting) begin
            m_shifting = 0;
            m_loaded = (m_bits == CFG);
            m_err = !m_loaded;
        end else if (en && commit && m_loaded) begin
            for (int k = 0; k < NM; k++) m_act[k] = shadow_field(k);
            m_valid = 1; m_loaded = 0;
        end
    endfunction

    function automatic void model_route(output logic [NUM_LE*LI-1:0] li,
                                        output logic [WIDTH-1:0] so, output logic [WIDTH-1:0] co);
        int s;
        bit done;
        li = '0; so = '0; co = '0;
        if (!m_valid) return;
        for (int le = 0; le < NUM_LE; le++)
            for (int i = 0; i < LI; i++) begin
                s = m_act[le*(LI+LO)+i];
                li[le*LI+i] = (s < WIDTH) ? (sb_bus_in[s] | cb_bus_in[s]) : (s == WIDTH + 1);
            end
        for (int j = 0; j < WIDTH; j++) begin
            so[j] = cb_bus_in[j];
            co[j] = sb_bus_in[j];
            done = 0;
            for (int le = 0; le < NUM_LE; le++)
                for (int o = 0; o < LO; o++)
                    if (!done && m_act[le*(LI+LO)+LI+o] == j) begin
                        so[j] = le_out[le*LO+o];
                        co[j] = le_out[le*LO+o];
                        done = 1;
                    end
        end
    endfunction

    function automatic bit frame_bit(int n);
        int k = NM - 1 - n / SB;
        int b = SB - 1 - n % SB;
        return bit'((f_sel[k] >> b) & 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_bus();
        sb_bus_in = $urandom;
        cb_bus_in = $urandom;
        le_out = 2'($urandom);
    endtask

    task automatic shift_frame(int n);
        for (int i = 0; i < n; i++) begin
            en = 1; config_en = 1; config_data_in = frame_bit(i);
            tick();
        end
        config_en = 0;
        tick();
    endtask

    task automatic commit_pulse();
        commit = 1;
        tick();
        commit = 0;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < NM; k++) f_sel[k] = $urandom_range(0, 63);
    endtask

    task automatic test_reset();
        nrst = 0; en = 0; config_en = 0; config_data_in = 0; commit = 0;
        sb_bus_in = '1; cb_bus_in = '0; le_out = '0;
        model_reset();
        #12;
        checks++;
        if (le_in !== '0 || sb_bus_out !== '0 || cb_bus_out !== '0) begin
            errors++; $display("FAIL reset_outputs: le_in=%h sb=%h cb=%h want 0", le_in, sb_bus_out, cb_bus_out);
        end
        checks++;
        if (config_data_out !== 1'b1 || cfg_loaded !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_status: cdo=%b ld=%b err=%b want 1 0 0", config_data_out, cfg_loaded, frame_err);
        end
        nrst = 1; en = 1;
        tick();
        commit_pulse();
        checks++;
        if (le_in !== '0 || sb_bus_out !== '0 || cb_bus_out !== '0) begin
            errors++; $display("FAIL reset_commit_ignored: le_in=%h sb=%h cb=%h want 0", le_in, sb_bus_out, cb_bus_out);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < NM; k++) f_sel[k] = 63;
        f_sel[0] = 3; f_sel[1] = 32; f_sel[2] = 33; f_sel[4] = 5;
        shift_frame(CFG);
        checks++;
        if (cfg_loaded !== 1'b1 || frame_err !== 1'b0) begin
            errors++; $display("FAIL basic_loaded: ld=%b err=%b want 1 0", cfg_loaded, frame_err);
        end
        checks++;
        if (config_data_out !== 1'b1) begin
            errors++; $display("FAIL basic_cdo: got %b want 1", config_data_out);
        end
        commit_pulse();
        sb_bus_in = 32'h8; cb_bus_in = '0; le_out = 2'b01;
        #1;
        checks++;
        if (le_in[3:0] !== 4'b0101) begin
            errors++; $display("FAIL basic_le_in: got %b want 0101", le_in[3:0]);
        end
        checks++;
        if (sb_bus_out[5] !== 1'b1 || cb_bus_out[5] !== 1'b1) begin
            errors++; $display("FAIL basic_track5: sb=%b cb=%b want 1 1", sb_bus_out[5], cb_bus_out[5]);
        end
        for (int i = 0; i < 10; i++) begin
            rand_bus(); #1;
            model_route(e_li, e_sb, e_cb);
            checks++;
            if (le_in !== e_li || sb_bus_out !== e_sb || cb_bus_out !== e_cb) begin
                errors++; $display("FAIL basic_route: got %h %h %h want %h %h %h", le_in, sb_bus_out, cb_bus_out, e_li, e_sb, e_cb);
            end
        end
    endtask

    task automatic test_shadow();
        rand_frame();
        for (int i = 0; i < CFG; i++) begin
            en = 1; config_en = 1; config_data_in = frame_bit(i);
            rand_bus();
            tick();
            model_route(e_li, e_sb, e_cb);
            checks++;
            if (le_in !== e_li || sb_bus_out !== e_sb || cb_bus_out !== e_cb) begin
                errors++; $display("FAIL shadow_route bit %0d: got %h %h %h want %h %h %h", i, le_in, sb_bus_out, cb_bus_out, e_li, e_sb, e_cb);
            end
            checks++;
            if (config_data_out !== sh_q[0]) begin
                errors++; $display("FAIL shadow_cdo bit %0d: got %b want %b", i, config_data_out, sh_q[0]);
            end
        end
        config_en = 0;
        tick();
        commit_pulse();
        for (int i = 0; i < 8; i++) begin
            rand_bus(); #1;
            model_route(e_li, e_sb, e_cb);
            checks++;
            if (le_in !== e_li || sb_bus_out !== e_sb || cb_bus_out !== e_cb) begin
                errors++; $display("FAIL shadow_commit_route: got %h %h %h want %h %h %h", le_in, sb_bus_out, cb_bus_out, e_li, e_sb, e_cb);
            end
        end
    endtask

    task automatic test_short_frame();
        rand_frame();
        shift_frame(CFG - 1);
        checks++;
        if (frame_err !== 1'b1 || cfg_loaded !== 1'b0) begin
            errors++; $display("FAIL short_status: err=%b ld=%b want 1 0", frame_err, cfg_loaded);
        end
        commit_pulse();
        rand_bus(); #1;
        model_route(e_li, e_sb, e_cb);
        checks++;
        if (le_in !== e_li || sb_bus_out !== e_sb || cb_bus_out !== e_cb || frame_err !== 1'b1) begin
            errors++; $display("FAIL short_commit_ignored: got %h %h %h err=%b want %h %h %h 1", le_in, sb_bus_out, cb_bus_out, frame_err, e_li, e_sb, e_cb);
        end
        shift_frame(CFG);
        checks++;
        if (frame_err !== 1'b0 || cfg_loaded !== 1'b1) begin
            errors++; $display("FAIL short_reshift: err=%b ld=%b want 0 1", frame_err, cfg_loaded);
        end
        commit_pulse();
        rand_bus(); #1;
        model_route(e_li, e_sb, e_cb);
        checks++;
        if (le_in !== e_li || sb_bus_out !== e_sb || cb_bus_out !== e_cb) begin
            errors++; $display("FAIL short_new_route: got %h %h %h want %h %h %h", le_in, sb_bus_out, cb_bus_out, e_li, e_sb, e_cb);
        end
    endtask

    task automatic test_priority();
        rand_frame();
        f_sel[4] = 7; f_sel[9] = 7;
        shift_frame(CFG);
        commit_pulse();
        sb_bus_in = '0; cb_bus_in = 32'h200; le_out = 2'b10;
        #1;
        checks++;
        if (sb_bus_out[7] !== 1'b0 || cb_bus_out[7] !== 1'b0) begin
            errors++; $display("FAIL prio_le0_wins: sb=%b cb=%b want 0 0", sb_bus_out[7], cb_bus_out[7]);
        end
        checks++;
        if (sb_bus_out[9] !== 1'b1 || cb_bus_out[9] !== 1'b0) begin
            errors++; $display("FAIL prio_passthru9: sb=%b cb=%b want 1 0", sb_bus_out[9], cb_bus_out[9]);
        end
        le_out = 2'b01; #1;
        checks++;
        if (sb_bus_out[7] !== 1'b1 || cb_bus_out[7] !== 1'b1) begin
            errors++; $display("FAIL prio_le0_one: sb=%b cb=%b want 1 1", sb_bus_out[7], cb_bus_out[7]);
        end
        f_sel[4] = 40;
        shift_frame(CFG);
        commit_pulse();
        sb_bus_in = '0; cb_bus_in = '0; le_out = 2'b10; #1;
        checks++;
        if (sb_bus_out[7] !== 1'b1 || cb_bus_out[7] !== 1'b1) begin
            errors++; $display("FAIL prio_high_sel_drives_nothing: sb=%b cb=%b want 1 1", sb_bus_out[7], cb_bus_out[7]);
        end
    endtask

    task automatic test_en_hold();
        rand_frame();
        shift_frame(CFG);
        en = 0; config_en = 1; config_data_in = ~sh_q[0];
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (cfg_loaded !== 1'b1 || config_data_out !== sh_q[0]) begin
            errors++; $display("FAIL en_hold: ld=%b cdo=%b want 1 %b", cfg_loaded, config_data_out, sh_q[0]);
        end
        config_en = 0; en = 1;
        commit_pulse();
        rand_bus(); #1;
        model_route(e_li, e_sb, e_cb);
        checks++;
        if (le_in !== e_li || sb_bus_out !== e_sb || cb_bus_out !== e_cb) begin
            errors++; $display("FAIL en_hold_route: got %h %h %h want %h %h %h", le_in, sb_bus_out, cb_bus_out, e_li, e_sb, e_cb);
        end
    endtask

    task automatic test_reset_mid();
        rand_frame();
        for (int i = 0; i < 30; i++) begin
            en = 1; config_en = 1; config_data_in = frame_bit(i);
            tick();
        end
        nrst = 0;
        model_reset();
        #1;
        checks++;
        if (le_in !== '0 || sb_bus_out !== '0 || cb_bus_out !== '0 || config_data_out !== 1'b1
            || cfg_loaded !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid: le_in=%h sb=%h cb=%h cdo=%b ld=%b err=%b", le_in, sb_bus_out, cb_bus_out, config_data_out, cfg_loaded, frame_err);
        end
        #2;
        nrst = 1; config_en = 0;
        tick();
        commit_pulse();
        rand_bus(); #1;
        checks++;
        if (le_in !== '0 || sb_bus_out !== '0 || cb_bus_out !== '0) begin
            errors++; $display("FAIL reset_mid_commit_ignored: le_in=%h sb=%h cb=%h want 0", le_in, sb_bus_out, cb_bus_out);
        end
        shift_frame(CFG);
        commit_pulse();
        rand_bus(); #1;
        model_route(e_li, e_sb, e_cb);
        checks++;
        if (le_in !== e_li || sb_bus_out !== e_sb || cb_bus_out !== e_cb) begin
            errors++; $display("FAIL reset_mid_route: got %h %h %h want %h %h %h", le_in, sb_bus_out, cb_bus_out, e_li, e_sb, e_cb);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            shift_frame(CFG);
            commit_pulse();
            for (int i = 0; i < 6; i++) begin
                rand_bus(); #1;
                model_route(e_li, e_sb, e_cb);
                checks++;
                if (le_in !== e_li || sb_bus_out !== e_sb || cb_bus_out !== e_cb) begin
                    errors++; $display("FAIL random_route f%0d: got %h %h %h want %h %h %h", f, le_in, sb_bus_out, cb_bus_out, e_li, e_sb, e_cb);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shadow();
        test_short_frame();
        test_priority();
        test_en_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
